glyph_column_decoder: RTL and testbench
=======================================

GLYPH_COLUMN_DECODER -- requirements
Module: glyph_column_decoder

Interface
REQ-001 SHALL have parameter GLYPH_W, default 4, meaning glyph columns and rows per character.
REQ-002 SHALL have port clk  input  1  single clock; all logic samples on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port col_valid  input  1  the column_in/line_in pair is valid this cycle.
REQ-005 SHALL have port column_in  input  4  scan column index: [3:2] is the character position, [1:0] is the column within the glyph.
REQ-006 SHALL have port line_in  input  4  column pixels: [3] is row 0 (top) through [0] is row 3 (bottom).
REQ-007 SHALL have port char_valid  output  1  one-cycle pulse; a glyph matched.
REQ-008 SHALL have port char_code  output  4  hex code of the matched glyph; held until the next match.
REQ-009 SHALL have port char_position  output  2  position of the last completed glyph, matched or not.
REQ-010 SHALL have port char_error  output  1  one-cycle pulse; a complete glyph matched no table entry.
REQ-011 SHALL have port seq_error  output  1  one-cycle pulse; a column arrived out of order and the partial glyph was discarded.
REQ-012 SHALL have port chars_out  output  16  last matched code per position: [4p+3:4p] is position p.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse; positions 0..3 each matched in ascending order without an intervening error.

Function
REQ-014 SHALL reconstruct a 16-bit glyph g in which column c sets g[15-c]=line_in[3], g[11-c]=line_in[2], g[7-c]=line_in[1] and g[3-c]=line_in[0].
REQ-015 SHALL track an expected column counter exp_col (2 bits) and a latched position cur_pos; both are 0 at reset.
REQ-016 SHALL accept a beat when col_valid=1 and column_in[1:0]==exp_col and (exp_col==0 or column_in[3:2]==cur_pos).
  - On an accepted beat at column 0, latch cur_pos=column_in[3:2].
  - Increment exp_col, wrapping 3->0.
REQ-017 SHALL treat any other valid beat as follows:
  - Pulse seq_error and clear the partial glyph.
  - Set exp_col=0.
  - If that beat is itself column 0, accept it as the start of a new glyph in the same cycle.
REQ-018 SHALL, on acceptance of column 3, compare the completed glyph against the 16-entry glyph table in the cycle after (latency 1).
  - Drive char_position=cur_pos.
  - On a match: pulse char_valid, set char_code, update the chars_out slot.
  - On no match: pulse char_error and leave chars_out unchanged.
REQ-019 SHALL use this glyph table, codes 0..F: F99F, F22F, F24F, F71F, 99F1, F8F7, 8F9F, F111, EBD7, F9F1, F9F9, CADA, F88F, E99E, FE8F, F8E8 (hex).
REQ-020 SHALL ignore beats while col_valid=0, with no timeout; a partial glyph is held indefinitely.
REQ-021 SHALL keep a frame tracker next_pos (reset 0).
  - A match at position next_pos increments next_pos.
  - When that match is at position 3, pulse frame_done in the same cycle as char_valid and set next_pos=0.
  - Any other match, char_error or seq_error sets next_pos=0, except that a match at position 0 sets next_pos=1.
REQ-022 SHALL accept back-to-back beats every cycle, so one glyph is decoded per 4 cycles with no bubbles.
REQ-023 SHALL produce char_valid and char_error as mutually exclusive signals; seq_error may coincide with either.

Reset
REQ-024 SHALL, while reset=1, clear the following to 0 regardless of col_valid, discarding any partial glyph:
  - exp_col, cur_pos and next_pos;
  - the glyph register and chars_out;
  - char_code and char_position;
  - all pulse outputs.
REQ-025 SHALL treat the first rising edge after reset deasserts as able to accept a column-0 beat.

Structure
REQ-026 SHALL obtain the glyph table constant, GLYPH_W, and the code/position widths from the shared package display_pkg, which the display scanner also uses.
REQ-027 SHALL place the combinational table match (16-bit glyph in; hit and 4-bit code out) in sub-module glyph_matcher; all state stays in the parent.

Verification
REQ-028 SHALL cover: position 1, columns 1001,1001,1111,1001 on 4 consecutive cycles -> next cycle char_valid=1, char_code=1, char_position=1, chars_out[7:4]=1.
REQ-029 SHALL cover: 16 consecutive beats encoding codes 0,A,5,F at positions 0..3 -> chars_out=F5A0 (hex) and a single frame_done pulse coinciding with the 4th char_valid.
REQ-030 SHALL cover: position 2, columns 0,1 then column 3 -> seq_error pulse, no char_valid, exp_col returns to 0.
REQ-031 SHALL cover: columns reconstructing 0000 (hex) -> char_error pulse, char_valid=0, chars_out unchanged.
REQ-032 SHALL cover: reset=1 asserted after columns 0..2 with col_valid=1 held, then column 3 after reset -> no char_valid, seq_error pulse, all outputs stay 0.
REQ-033 SHALL cover: col_valid gaps of 3 cycles between each beat of a code-8 glyph -> char_valid with char_code=8 one cycle after the final beat.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants: glyph geometry, field widths and the 4x4 hex glyph table.
// Used by the column decoder and by the display scanner.
package display_pkg;

    localparam int GLYPH_W    = 4;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_W;
    localparam int CODE_W     = 4;
    localparam int POS_W      = 2;
    localparam int COL_W      = 2;
    localparam int NUM_GLYPHS = 16;
    localparam int NUM_POS    = 4;

    typedef logic [GLYPH_BITS-1:0] glyph_t;
    typedef logic [CODE_W-1:0]     code_t;
    typedef logic [POS_W-1:0]      pos_t;
    typedef logic [COL_W-1:0]      col_t;

    // Entry i is the row-major bitmap of hex digit i (row 0 in the top nibble).
    localparam logic [NUM_GLYPHS-1:0][GLYPH_BITS-1:0] GLYPH_TABLE = {
        16'hF8E8, 16'hFE8F, 16'hE99E, 16'hF88F,
        16'hCADA, 16'hF9F9, 16'hF9F1, 16'hEBD7,
        16'hF111, 16'h8F9F, 16'hF8F7, 16'h99F1,
        16'hF71F, 16'hF24F, 16'hF22F, 16'hF99F
    };

endpackage

// File: rtl/glyph_column_decoder_if.sv
// Column-scan input and decoded-character output bundle of the glyph column decoder.
interface glyph_column_decoder_if;
    import display_pkg::*;

    logic                       col_valid;
    logic [POS_W+COL_W-1:0]     column_in;
    logic [GLYPH_W-1:0]         line_in;
    logic                       char_valid;
    logic [CODE_W-1:0]          char_code;
    logic [POS_W-1:0]           char_position;
    logic                       char_error;
    logic                       seq_error;
    logic [NUM_POS*CODE_W-1:0]  chars_out;
    logic                       frame_done;

    modport master (
        output col_valid, column_in, line_in,
        input  char_valid, char_code, char_position, char_error,
        input  seq_error, chars_out, frame_done
    );

    modport slave (
        input  col_valid, column_in, line_in,
        output char_valid, char_code, char_position, char_error,
        output seq_error, chars_out, frame_done
    );

endinterface

// File: rtl/glyph_matcher.sv
// Combinational lookup of a completed 4x4 glyph against the hex glyph table.
module glyph_matcher
    import display_pkg::*;
(
    input  glyph_t glyph_i,
    output logic   hit_o,
    output code_t  code_o
);

    logic [NUM_GLYPHS-1:0] entry_eq;

    for (genvar gi = 0; gi < NUM_GLYPHS; gi++) begin : g_entry
        assign entry_eq[gi] = (glyph_i == GLYPH_TABLE[gi]);
    end

    // Table entries are distinct, so at most one bit of entry_eq is set.
    always_comb begin
        hit_o  = 1'b0;
        code_o = '0;
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (entry_eq[i]) begin
                hit_o  = 1'b1;
                code_o = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/glyph_column_decoder.sv
// Assembles scanned glyph columns, decodes each completed glyph to a hex code one
// cycle after its last column, and tracks in-order frames of four positions.
module glyph_column_decoder #(
    parameter int GLYPH_W = display_pkg::GLYPH_W
) (
    input  logic                  clk,
    input  logic                  reset,
    glyph_column_decoder_if.slave bus
);

    localparam int GLYPH_BITS = GLYPH_W * GLYPH_W;
    localparam int COL_W      = display_pkg::COL_W;
    localparam int POS_W      = display_pkg::POS_W;
    localparam int CODE_W     = display_pkg::CODE_W;
    localparam int NUM_POS    = display_pkg::NUM_POS;
    localparam int CHARS_W    = NUM_POS * CODE_W;

    logic [COL_W-1:0]      exp_col_q,    exp_col_d;
    logic [POS_W-1:0]      cur_pos_q,    cur_pos_d;
    logic [POS_W-1:0]      next_pos_q,   next_pos_d;
    logic [GLYPH_BITS-1:0] glyph_q,      glyph_d;
    logic [CHARS_W-1:0]    chars_q,      chars_d;
    logic [CODE_W-1:0]     char_code_q,  char_code_d;
    logic [POS_W-1:0]      char_pos_q,   char_pos_d;
    logic                  char_valid_q, char_valid_d;
    logic                  char_error_q, char_error_d;
    logic                  seq_error_q,  seq_error_d;
    logic                  frame_done_q, frame_done_d;

    logic [COL_W-1:0]      beat_col;
    logic [POS_W-1:0]      beat_pos;
    logic                  in_order;
    logic                  out_of_order;
    logic                  start;
    logic                  take;
    logic                  complete;
    logic [GLYPH_BITS-1:0] glyph_base;
    logic [GLYPH_BITS-1:0] glyph_upd;
    logic                  match_hit;
    logic [CODE_W-1:0]     match_code;
    logic                  match_ok;

    assign beat_col = bus.column_in[COL_W-1:0];
    assign beat_pos = bus.column_in[COL_W+POS_W-1:COL_W];

    // Column 0 may start any position; later columns must continue the latched one.
    assign in_order     = bus.col_valid && (beat_col == exp_col_q) &&
                          ((exp_col_q == '0) || (beat_pos == cur_pos_q));
    assign out_of_order = bus.col_valid && !in_order;
    assign start        = bus.col_valid && (beat_col == '0);
    assign take         = in_order || start;
    assign complete     = in_order && (beat_col == COL_W'(GLYPH_W-1));

    assign glyph_base = start ? '0 : glyph_q;

    // Bit r*W + (W-1-c) of the glyph holds line_in[r] of column c.
    for (genvar gi = 0; gi < GLYPH_BITS; gi++) begin : g_bit
        assign glyph_upd[gi] = (beat_col == COL_W'(GLYPH_W - 1 - (gi % GLYPH_W)))
                               ? bus.line_in[gi / GLYPH_W] : glyph_base[gi];
    end

    glyph_matcher u_matcher (
        .glyph_i (glyph_upd),
        .hit_o   (match_hit),
        .code_o  (match_code)
    );

    assign match_ok = complete && match_hit;

    for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_slot
        assign chars_d[gi*CODE_W +: CODE_W] =
            (match_ok && (cur_pos_q == POS_W'(gi))) ? match_code
                                                    : chars_q[gi*CODE_W +: CODE_W];
    end

    always_comb begin
        exp_col_d    = exp_col_q;
        cur_pos_d    = cur_pos_q;
        next_pos_d   = next_pos_q;
        glyph_d      = glyph_q;
        char_code_d  = char_code_q;
        char_pos_d   = char_pos_q;
        char_valid_d = 1'b0;
        char_error_d = 1'b0;
        seq_error_d  = out_of_order;
        frame_done_d = 1'b0;

        if (take) begin
            glyph_d   = glyph_upd;
            exp_col_d = beat_col + 1'b1;
            if (start) begin
                cur_pos_d = beat_pos;
            end
        end else if (out_of_order) begin
            glyph_d   = '0;
            exp_col_d = '0;
        end

        if (complete) begin
            char_pos_d = cur_pos_q;
            if (match_hit) begin
                char_valid_d = 1'b1;
                char_code_d  = match_code;
            end else begin
                char_error_d = 1'b1;
            end
        end

        // Frame tracking: positions must match 0,1,2,3 in order with no error between.
        if (match_ok) begin
            if (cur_pos_q == next_pos_q) begin
                if (cur_pos_q == POS_W'(NUM_POS-1)) begin
                    frame_done_d = 1'b1;
                    next_pos_d   = '0;
                end else begin
                    next_pos_d = next_pos_q + 1'b1;
                end
            end else if (cur_pos_q == '0) begin
                next_pos_d = POS_W'(1);
            end else begin
                next_pos_d = '0;
            end
        end else if (complete || out_of_order) begin
            next_pos_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_col_q    <= '0;
            cur_pos_q    <= '0;
            next_pos_q   <= '0;
            glyph_q      <= '0;
            chars_q      <= '0;
            char_code_q  <= '0;
            char_pos_q   <= '0;
            char_valid_q <= 1'b0;
            char_error_q <= 1'b0;
            seq_error_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            exp_col_q    <= exp_col_d;
            cur_pos_q    <= cur_pos_d;
            next_pos_q   <= next_pos_d;
            glyph_q      <= glyph_d;
            chars_q      <= chars_d;
            char_code_q  <= char_code_d;
            char_pos_q   <= char_pos_d;
            char_valid_q <= char_valid_d;
            char_error_q <= char_error_d;
            seq_error_q  <= seq_error_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.char_valid    = char_valid_q;
    assign bus.char_code     = char_code_q;
    assign bus.char_position = char_pos_q;
    assign bus.char_error    = char_error_q;
    assign bus.seq_error     = seq_error_q;
    assign bus.chars_out     = chars_q;
    assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_glyph_column_decoder.sv
// Directed bench for glyph_column_decoder: each glyph is given as four column nibbles
// {col0,col1,col2,col3} with hand-derived expected codes and frame behaviour.
module tb_glyph_column_decoder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    glyph_column_decoder_if bus ();

    glyph_column_decoder #(.GLYPH_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [1:0] pos, input logic [1:0] col, input logic [3:0] line);
        bus.col_valid = 1'b1;
        bus.column_in = {pos, col};
        bus.line_in   = line;
        tick();
    endtask

    task automatic idle(input int n);
        bus.col_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic glyph4(input logic [1:0] pos, input logic [15:0] cols);
        beat(pos, 2'd0, cols[15:12]);
        beat(pos, 2'd1, cols[11:8]);
        beat(pos, 2'd2, cols[7:4]);
        beat(pos, 2'd3, cols[3:0]);
        $display("glyph pos=%0d cols=%h -> valid=%0b code=%h err=%0b seq=%0b frame=%0b chars=%h",
                 pos, cols, bus.char_valid, bus.char_code, bus.char_error,
                 bus.seq_error, bus.frame_done, bus.chars_out);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".char_valid"}, 16'(bus.char_valid),    16'h0);
        check({tag, ".char_error"}, 16'(bus.char_error),    16'h0);
        check({tag, ".frame_done"}, 16'(bus.frame_done),    16'h0);
        check({tag, ".char_code"},  16'(bus.char_code),     16'h0);
        check({tag, ".char_pos"},   16'(bus.char_position), 16'h0);
        check({tag, ".chars_out"},  bus.chars_out,          16'h0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.col_valid = 1'b0;
        bus.column_in = '0;
        bus.line_in   = '0;
        repeat (3) tick();
        check_all_zero("reset");
        check("reset.seq_error", 16'(bus.seq_error), 16'h0);
        reset = 1'b0;

        // Code 1 (F22F) at position 1, starting on the first edge after reset.
        glyph4(2'd1, 16'h99F9);
        check("p1.valid", 16'(bus.char_valid),    16'h1);
        check("p1.code",  16'(bus.char_code),     16'h1);
        check("p1.pos",   16'(bus.char_position), 16'h1);
        check("p1.chars", bus.chars_out,          16'h0010);
        check("p1.err",   16'(bus.char_error),    16'h0);
        check("p1.frame", 16'(bus.frame_done),    16'h0);
        idle(1);
        check("p1.pulse_end", 16'(bus.char_valid), 16'h0);

        // Back-to-back frame: codes 0, A, 5, F at positions 0..3.
        glyph4(2'd0, 16'hF99F);
        check("fr0.code",  16'(bus.char_code),  16'h0);
        check("fr0.frame", 16'(bus.frame_done), 16'h0);
        glyph4(2'd1, 16'hFAAF);
        check("fr1.code",  16'(bus.char_code),  16'hA);
        check("fr1.frame", 16'(bus.frame_done), 16'h0);
        glyph4(2'd2, 16'hEBBB);
        check("fr2.code",  16'(bus.char_code),  16'h5);
        check("fr2.frame", 16'(bus.frame_done), 16'h0);
        glyph4(2'd3, 16'hFAA8);
        check("fr3.valid", 16'(bus.char_valid), 16'h1);
        check("fr3.code",  16'(bus.char_code),  16'hF);
        check("fr3.frame", 16'(bus.frame_done), 16'h1);
        check("fr3.chars", bus.chars_out,       16'hF5A0);
        idle(1);
        check("fr.frame_end", 16'(bus.frame_done), 16'h0);

        // Position 2: columns 0,1 then 3 is out of order.
        beat(2'd2, 2'd0, 4'h9);
        beat(2'd2, 2'd1, 4'hD);
        check("sq.no_err_yet", 16'(bus.seq_error), 16'h0);
        beat(2'd2, 2'd3, 4'hF);
        $display("beat pos=2 col=3 out of order -> seq=%0b valid=%0b", bus.seq_error, bus.char_valid);
        check("sq.seq",   16'(bus.seq_error),  16'h1);
        check("sq.valid", 16'(bus.char_valid), 16'h0);
        check("sq.err",   16'(bus.char_error), 16'h0);
        glyph4(2'd2, 16'h9DDF);
        check("sq.recover_valid", 16'(bus.char_valid), 16'h1);
        check("sq.recover_code",  16'(bus.char_code),  16'h3);
        check("sq.recover_chars", bus.chars_out,       16'hF3A0);
        idle(1);

        // Blank glyph matches nothing.
        glyph4(2'd0, 16'h0000);
        check("blank.err",   16'(bus.char_error),    16'h1);
        check("blank.valid", 16'(bus.char_valid),    16'h0);
        check("blank.chars", bus.chars_out,          16'hF3A0);
        check("blank.pos",   16'(bus.char_position), 16'h0);
        check("blank.code",  16'(bus.char_code),     16'h3);
        idle(1);
        check("blank.pulse_end", 16'(bus.char_error), 16'h0);

        // Column 0 arriving mid-glyph restarts at the new position.
        beat(2'd1, 2'd0, 4'hF);
        beat(2'd1, 2'd1, 4'h0);
        beat(2'd3, 2'd0, 4'h9);
        $display("beat pos=3 col=0 restart -> seq=%0b", bus.seq_error);
        check("rs.seq", 16'(bus.seq_error), 16'h1);
        beat(2'd3, 2'd1, 4'h9);
        check("rs.seq_end", 16'(bus.seq_error), 16'h0);
        beat(2'd3, 2'd2, 4'hF);
        beat(2'd3, 2'd3, 4'h9);
        check("rs.valid", 16'(bus.char_valid),    16'h1);
        check("rs.code",  16'(bus.char_code),     16'h1);
        check("rs.pos",   16'(bus.char_position), 16'h3);
        check("rs.chars", bus.chars_out,          16'h13A0);
        check("rs.frame", 16'(bus.frame_done),    16'h0);

        // Error at position 2 breaks the frame.
        glyph4(2'd0, 16'hF99F);
        glyph4(2'd1, 16'hF99F);
        glyph4(2'd2, 16'h0000);
        check("brk.err", 16'(bus.char_error), 16'h1);
        glyph4(2'd3, 16'hF99F);
        check("brk.valid", 16'(bus.char_valid), 16'h1);
        check("brk.frame", 16'(bus.frame_done), 16'h0);
        check("brk.chars", bus.chars_out,       16'h0300);
        idle(1);

        // Code 8 with three idle cycles between beats.
        beat(2'd0, 2'd0, 4'hE);
        idle(3);
        beat(2'd0, 2'd1, 4'hB);
        idle(3);
        beat(2'd0, 2'd2, 4'hD);
        idle(3);
        check("gap.no_valid", 16'(bus.char_valid), 16'h0);
        beat(2'd0, 2'd3, 4'h7);
        $display("beat pos=0 col=3 after gaps -> valid=%0b code=%h", bus.char_valid, bus.char_code);
        check("gap.valid", 16'(bus.char_valid), 16'h1);
        check("gap.code",  16'(bus.char_code),  16'h8);
        check("gap.chars", bus.chars_out,       16'h0308);
        idle(1);

        // Reset in the middle of a glyph with col_valid held high.
        beat(2'd0, 2'd0, 4'hF);
        beat(2'd0, 2'd1, 4'h9);
        bus.col_valid = 1'b1;
        bus.column_in = {2'd0, 2'd2};
        bus.line_in   = 4'h9;
        reset         = 1'b1;
        tick();
        tick();
        check_all_zero("mrst");
        check("mrst.seq", 16'(bus.seq_error), 16'h0);
        reset         = 1'b0;
        bus.column_in = {2'd0, 2'd3};
        bus.line_in   = 4'hF;
        tick();
        $display("beat pos=0 col=3 after reset -> seq=%0b valid=%0b", bus.seq_error, bus.char_valid);
        check("mrst.after_seq", 16'(bus.seq_error), 16'h1);
        check_all_zero("mrst.after");
        idle(1);
        check("mrst.seq_end", 16'(bus.seq_error), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
